// File: rtl/cnn_core_ctrl_pkg.sv
// cnn_core_ctrl_pkg: FSM encoding and default sizes for the CNN core pass sequencer
package cnn_core_ctrl_pkg;
  localparam int WIN_BW_DEF = 16;
  localparam int MAX_INFLIGHT_DEF = 8;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;
endpackage

// File: rtl/cnn_core_ctrl_if.sv
// cnn_core_ctrl_if: pass control, window issue and result return signals of one CNN core
interface cnn_core_ctrl_if #(parameter int WIN_BW = cnn_core_ctrl_pkg::WIN_BW_DEF);
  logic start;
  logic [WIN_BW-1:0] cfg_num_win;
  logic busy;
  logic done;
  logic src_valid;
  logic src_ready;
  logic core_in_valid;
  logic [WIN_BW-1:0] core_win_idx;
  logic relu_valid;
  logic out_pop;
  logic [WIN_BW-1:0] res_cnt;
  logic err;
  modport slave (
    input start, cfg_num_win, src_valid, relu_valid, out_pop,
    output busy, done, src_ready, core_in_valid, core_win_idx, res_cnt, err
  );
  modport master (
    output start, cfg_num_win, src_valid, relu_valid, out_pop,
    input busy, done, src_ready, core_in_valid, core_win_idx, res_cnt, err
  );
endinterface

// File: rtl/cnn_credit_cnt.sv
// cnn_credit_cnt: up/down credit counter for a buffer of MAX entries
// A return while already full is dropped and flagged on ovf.
module cnn_credit_cnt #(
  parameter int MAX = 8,
  parameter int BW = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          dec,
  input  logic          inc,
  output logic [BW-1:0] credits,
  output logic          ovf
);
  localparam logic [BW-1:0] FULL = BW'(MAX);
  logic [BW-1:0] nxt;
  always_comb begin
    ovf = inc & (credits == FULL);
    nxt = load ? FULL : credits + BW'(inc & ~ovf) - BW'(dec & |credits);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) credits <= FULL;
    else credits <= nxt;
endmodule

// File: rtl/cnn_core_ctrl.sv
// cnn_core_ctrl: issues a programmed number of windows into the CNN core under credit
// control and counts rectified results back until the pass completes
module cnn_core_ctrl #(
  parameter int WIN_BW = cnn_core_ctrl_pkg::WIN_BW_DEF,
  parameter int MAX_INFLIGHT = cnn_core_ctrl_pkg::MAX_INFLIGHT_DEF,
  parameter int CRD_BW = $clog2(MAX_INFLIGHT + 1)
) (
  input logic clk,
  input logic reset_n,
  cnn_core_ctrl_if.slave bus
);
  import cnn_core_ctrl_pkg::*;
  state_t state, state_n;
  logic [WIN_BW-1:0] num_win, iss_cnt, res_cnt, res_n;
  logic [CRD_BW-1:0] credits;
  logic accept, fire, active, relu_sat, ovf, err;
  assign accept = (state == S_IDLE) & bus.start;
  assign bus.src_ready = (state == S_RUN) & (iss_cnt < num_win) & (credits != '0);
  assign fire = bus.src_valid & bus.src_ready;
  assign active = (state == S_RUN) | (state == S_DRAIN);
  assign relu_sat = res_cnt == num_win;
  assign res_n = res_cnt + WIN_BW'(bus.relu_valid & active & ~relu_sat);
  assign bus.busy = (state != S_IDLE) | accept;
  assign bus.done = state == S_DONE;
  assign bus.res_cnt = res_cnt;
  assign bus.err = err;
  cnn_credit_cnt #(.MAX(MAX_INFLIGHT), .BW(CRD_BW)) u_crd (
    .clk(clk), .reset_n(reset_n), .load(accept), .dec(fire), .inc(bus.out_pop),
    .credits(credits), .ovf(ovf)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept) state_n = (bus.cfg_num_win == '0) ? S_DONE : S_RUN;
      S_RUN: if (fire && (iss_cnt + WIN_BW'(1) == num_win)) state_n = S_DRAIN;
      S_DRAIN: if (res_n == num_win) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      num_win <= '0;
      iss_cnt <= '0;
      res_cnt <= '0;
      err <= 1'b0;
      bus.core_in_valid <= 1'b0;
      bus.core_win_idx <= '0;
    end else begin
      bus.core_in_valid <= fire;
      if (fire) bus.core_win_idx <= iss_cnt;
      if (accept) begin
        num_win <= bus.cfg_num_win;
        iss_cnt <= '0;
        res_cnt <= '0;
        err <= 1'b0;
      end else begin
        iss_cnt <= iss_cnt + WIN_BW'(fire);
        res_cnt <= res_n;
        err <= err | ovf | (bus.relu_valid & (~active | relu_sat));
      end
    end
endmodule
